// File: rtl/uart_receiver.sv
// 8-bit UART receiver with 16x oversampling and a first-word-fall-through receive FIFO.
// Optional parity bit enabled by defining UART_PARITY_EN (even by default, odd when PARITY_ODD = 1).
module uart_receiver #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                          clk_50,
  input  logic                          rst_,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          ovr_err,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic          rx_s1_q, rx_s2_q;
  logic [1:0]    flush_q;
  logic          armed_q;
  logic [DW-1:0] div_q;
  logic          tick;
  state_t        state_q, state_d;
  logic [3:0]    tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_bad_q, par_bad_d;
  logic          brk_q, brk_d;
  logic          frame_err_q, frame_err_d;
  logic          ovr_err_q, ovr_err_d;
  logic          push_req, set_ferr;
  logic          push, pop, full, drop;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    mem [FIFO_DEPTH];

  assign tick = (div_q == DW'(DIV - 1));

  // armed_q becomes 1 only once the synchronized line has genuinely been seen high after reset,
  // so a line held low through reset release cannot be mistaken for a start edge.
  always_ff @(posedge clk_50 or negedge rst_) begin
    if (!rst_) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      flush_q <= 2'd0;
      armed_q <= 1'b0;
      div_q   <= '0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      flush_q <= (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
      armed_q <= armed_q | ((flush_q == 2'd2) & rx_s2_q);
      div_q   <= tick ? '0 : div_q + DW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    brk_d     = brk_q;
    push_req  = 1'b0;
    set_ferr  = 1'b0;
    case (state_q)
      IDLE: begin
        brk_d     = 1'b0;
        par_bad_d = 1'b0;
        if (armed_q && !rx_s2_q) begin
          state_d = START;
          tcnt_d  = 4'd0;
        end
      end
      START: begin
        if (tick) tcnt_d = tcnt_q + 4'd1;
        if (tick && tcnt_q == 4'd7) begin
          if (!rx_s2_q) begin
            state_d = DATA;
            tcnt_d  = 4'd0;
            bcnt_d  = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) tcnt_d = tcnt_q + 4'd1;
        if (tick && tcnt_q == 4'd15) begin
          shift_d = {rx_s2_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PAR_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (tick) tcnt_d = tcnt_q + 4'd1;
        if (tick && tcnt_q == 4'd15) begin
          par_bad_d = ((^shift_q) ^ rx_s2_q) != PARITY_ODD;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (brk_q) begin
          if (rx_s2_q) state_d = IDLE;
        end else begin
          if (tick) tcnt_d = tcnt_q + 4'd1;
          // A good stop sample ends the frame at mid-bit to leave margin for baud mismatch.
          if (tick && tcnt_q == 4'd15) begin
            if (rx_s2_q) begin
              if (par_bad_q) set_ferr = 1'b1;
              else           push_req = 1'b1;
              state_d = IDLE;
            end else begin
              set_ferr = 1'b1;
              brk_d    = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_) begin
    if (!rst_) begin
      state_q   <= IDLE;
      tcnt_q    <= 4'd0;
      bcnt_q    <= 3'd0;
      par_bad_q <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      par_bad_q <= par_bad_d;
      brk_q     <= brk_d;
    end
  end

  assign full        = (cnt_q == (AW + 1)'(FIFO_DEPTH));
  assign rx_valid    = (cnt_q != '0);
  assign pop         = rx_valid & rx_ready;
  assign push        = push_req & (~full | pop);
  assign drop        = push_req & full & ~pop;
  assign frame_err_d = (frame_err_q & ~err_clr) | set_ferr;
  assign ovr_err_d   = (ovr_err_q & ~err_clr) | drop;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_) begin
    if (!rst_) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      ovr_err_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
      ovr_err_q   <= ovr_err_d;
    end
  end

  // When full with a simultaneous pop, the write lands in the slot being read out this cycle.
  always_ff @(posedge clk_50) begin
    shift_q <= shift_d;
    if (push) mem[wptr_q] <= shift_q;
  end

  assign rx_data   = rx_valid ? mem[rptr_q] : 8'h00;
  assign fill      = cnt_q;
  assign frame_err = frame_err_q;
  assign ovr_err   = ovr_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at default parameters (432 clocks per bit).
module tb_uart_receiver;

  localparam int BIT_CYC = 432;

  logic       clk_50 = 1'b0;
  logic       rst_;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       ovr_err;
  logic       err_clr;
  logic [3:0] fill;

  logic rdy_force;
  logic rdy_on_push;
  bit   tx_busy;
  int   n_tests;
  int   n_fail;

  uart_receiver dut (
    .clk_50    (clk_50),
    .rst_      (rst_),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .ovr_err   (ovr_err),
    .err_clr   (err_clr),
    .fill      (fill)
  );

  // Pulse a pop exactly on the push cycle to exercise simultaneous push/pop on a full FIFO.
  assign rx_ready = rdy_force | (rdy_on_push & dut.push_req);

  always #10 clk_50 = ~clk_50;

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    tx_busy = 1'b1;
    rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk_50);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CYC) @(negedge clk_50);
    end
    rx = stop_bit;
    repeat (BIT_CYC) @(negedge clk_50);
    rx = 1'b1;
    tx_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0; rx = 1'b1; rdy_force = 1'b0; rdy_on_push = 1'b0; err_clr = 1'b0;
    repeat (5) @(negedge clk_50);
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_tests++; if (fill !== 4'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_tests++; if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL reset_oerr: got %b want 0", ovr_err); end
    rst_ = 1'b1;
    repeat (10) @(negedge clk_50);
  endtask

  task automatic test_latency();
    int cnt;
    rdy_force = 1'b1;
    @(negedge clk_50);
    fork
      send_byte(8'hA5, 1'b1);
    join_none
    cnt = 0;
    while (rx_valid !== 1'b1 && cnt < 6000) begin
      @(negedge clk_50);
      cnt++;
    end
    n_tests++; if (cnt < 4070 || cnt > 4140) begin n_fail++; $display("FAIL a5_latency: got %0d cycles want ~4100", cnt); end
    n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h want a5", rx_data); end
    n_tests++; if (fill !== 4'd1) begin n_fail++; $display("FAIL a5_fill: got %0d want 1", fill); end
    @(negedge clk_50);
    n_tests++; if (fill !== 4'd0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL a5_popped: got fill %0d valid %b want 0 0", fill, rx_valid); end
    while (tx_busy) @(negedge clk_50);
    rdy_force = 1'b0;
    repeat (10) @(negedge clk_50);
  endtask

  task automatic test_glitch();
    @(negedge clk_50);
    rx = 1'b0;
    repeat (100) @(negedge clk_50);
    rx = 1'b1;
    repeat (600) @(negedge clk_50);
    n_tests++; if (fill !== 4'd0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_push: got fill %0d valid %b want 0 0", fill, rx_valid); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_ferr: got %b want 0", frame_err); end
  endtask

  task automatic test_frame_err();
    send_byte(8'h3C, 1'b0);
    repeat (20) @(negedge clk_50);
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b want 1", frame_err); end
    n_tests++; if (fill !== 4'd0) begin n_fail++; $display("FAIL ferr_discard: got fill %0d want 0", fill); end
    err_clr = 1'b1;
    @(negedge clk_50);
    err_clr = 1'b0;
    @(negedge clk_50);
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1);
    repeat (20) @(negedge clk_50);
    n_tests++; if (fill !== 4'd8) begin n_fail++; $display("FAIL ovf_fill8: got %0d want 8", fill); end
    n_tests++; if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL ovf_noerr: got %b want 0", ovr_err); end
    send_byte(8'h08, 1'b1);
    repeat (20) @(negedge clk_50);
    n_tests++; if (fill !== 4'd8) begin n_fail++; $display("FAIL ovf_fill: got %0d want 8", fill); end
    n_tests++; if (ovr_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", ovr_err); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL ovf_head: got %h want 00", rx_data); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] want;
    err_clr = 1'b1;
    @(negedge clk_50);
    err_clr = 1'b0;
    @(negedge clk_50);
    n_tests++; if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL oerr_clear: got %b want 0", ovr_err); end
    rdy_on_push = 1'b1;
    send_byte(8'h09, 1'b1);
    rdy_on_push = 1'b0;
    repeat (5) @(negedge clk_50);
    n_tests++; if (fill !== 4'd8) begin n_fail++; $display("FAIL pp_fill: got %0d want 8", fill); end
    n_tests++; if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL pp_oerr: got %b want 0", ovr_err); end
    for (int i = 1; i < 8; i++) begin
      want = 8'(i);
      n_tests++; if (rx_data !== want) begin n_fail++; $display("FAIL pop_%0d: got %h want %h", i, rx_data, want); end
      rdy_force = 1'b1;
      @(negedge clk_50);
      rdy_force = 1'b0;
    end
    n_tests++; if (rx_data !== 8'h09 || fill !== 4'd1) begin n_fail++; $display("FAIL pp_tail: got %h fill %0d want 09 fill 1", rx_data, fill); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_50);
    fork
      send_byte(8'hFF, 1'b1);
    join_none
    repeat (1500) @(negedge clk_50);
    rst_ = 1'b0;
    repeat (3) @(negedge clk_50);
    n_tests++; if (fill !== 4'd0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_fifo: got fill %0d valid %b want 0 0", fill, rx_valid); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
    rst_ = 1'b1;
    while (tx_busy) @(negedge clk_50);
    repeat (20) @(negedge clk_50);
    n_tests++; if (fill !== 4'd0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_partial: got fill %0d ferr %b want 0 0", fill, frame_err); end
    send_byte(8'h12, 1'b1);
    repeat (5) @(negedge clk_50);
    n_tests++; if (rx_data !== 8'h12 || fill !== 4'd1) begin n_fail++; $display("FAIL rstmid_next: got %h fill %0d want 12 fill 1", rx_data, fill); end
    rdy_force = 1'b1;
    repeat (3) @(negedge clk_50);
    n_tests++; if (fill !== 4'd0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL empty_ready: got fill %0d valid %b want 0 0", fill, rx_valid); end
    rdy_force = 1'b0;
  endtask

  task automatic test_low_line_reset();
    rx = 1'b0;
    rst_ = 1'b0;
    repeat (3) @(negedge clk_50);
    rst_ = 1'b1;
    repeat (1000) @(negedge clk_50);
    rx = 1'b1;
    repeat (5000) @(negedge clk_50);
    n_tests++; if (fill !== 4'd0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL lowline_armed: got fill %0d ferr %b want 0 0", fill, frame_err); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tx_busy = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_low_line_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
